reg_status: RTL and testbench
=============================

REG_STATUS -- requirements
Module: reg_status

Interface
REQ-001 Parameters (name, default, meaning): NREG 32 architectural registers; XLEN 32 data width; ROB_W `ROB_SIZE_WIDTH RoB tag width; NRP 2 read ports.
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 rdy  in  1  global enable; state frozen when low.
REQ-005 issue_rob_id  in  ROB_W  tag of issuing instruction; 0 = no issue.
REQ-006 issue_rd  in  log2(NREG)  destination of issuing instruction.
REQ-007 commit_rob_id  in  ROB_W  tag of committing instruction; 0 = no commit.
REQ-008 commit_rd  in  log2(NREG)  destination of committing instruction.
REQ-009 commit_value  in  XLEN  committed result.
REQ-010 flush  in  1  misprediction; discard all speculative renames.
REQ-011 rd_addr  in  NRP*log2(NREG)  decoder source-register selects, packed.
REQ-012 rd_value  out  NRP*XLEN  operand value per port.
REQ-013 rd_has_dep  out  NRP  operand still pending per port.
REQ-014 rd_dep_id  out  NRP*ROB_W  producing RoB tag per port; 0 when no dependency.
REQ-015 ask_rob_id  out  NRP*ROB_W  RoB lookup tag per port.
REQ-016 rob_ready  in  NRP  RoB entry for ask_rob_id has its result.
REQ-017 rob_value  in  NRP*XLEN  RoB result for ask_rob_id.
REQ-018 busy_count  out  log2(NREG)+1  number of registers currently carrying a dependency.

Function
REQ-019 State: regs[NREG] of XLEN bits, has_dep[NREG], dep_id[NREG] of ROB_W bits, busy counter.
REQ-020 Reads are combinational and reflect state before this cycle's issue; the decoder's own issue never renames its own sources.
REQ-021 Per port: ask_rob_id = dep_id[addr] when has_dep[addr], else 0.
REQ-022 Operand priority per port: (a) addr==0 -> value 0, no dep; (b) no dep -> regs[addr]; (c) commit_rob_id!=0 and commit_rob_id==dep_id[addr] -> commit_value, no dep; (d) rob_ready -> rob_value, no dep; (e) otherwise has_dep=1, dep_id=dep_id[addr], value 0.
REQ-023 Commit (commit_rob_id!=0, commit_rd!=0): regs[commit_rd] <= commit_value; clear has_dep/dep_id only if dep_id[commit_rd]==commit_rob_id.
REQ-024 Issue (issue_rob_id!=0, issue_rd!=0): has_dep[issue_rd] <= 1, dep_id[issue_rd] <= issue_rob_id.
REQ-025 Same cycle, same register, issue and commit: regs is written, issue's rename wins (dep stays set with issue tag).
REQ-026 Writes to register 0 are ignored; x0 never carries a dependency.
REQ-027 flush: all has_dep and dep_id cleared next cycle, busy_count=0; the same-cycle commit still writes regs; the same-cycle issue is discarded.
REQ-028 busy_count tracks set has_dep bits exactly: +1 on issue to a register without a dependency, -1 on a clearing commit, net 0 when both hit different states as per REQ-025; never exceeds NREG-1.
REQ-029 rdy low: no state change; combinational outputs remain valid.

Reset
REQ-030 Asynchronous assertion (rst low): regs=0, has_dep=0, dep_id=0, busy_count=0 immediately; outputs follow per REQ-022.
REQ-031 Reset release is synchronised by the system; first update on first posedge with rst high and rdy high.

Structure
REQ-032 ROB_SIZE_WIDTH, XLEN and register-index width live in config.v; no new global constants.
REQ-033 One sub-module, reg_read_port, implementing REQ-021/022 for one port, instantiated NRP times via generate.

Verification
REQ-034 Issue tag 5 to x3, next cycle read x3 with rob_ready=0 -> has_dep=1, dep_id=5, ask_rob_id=5, busy_count=1.
REQ-035 x3 pending tag 5, rob_ready=1, rob_value=0xDEAD -> rd_value=0xDEAD, has_dep=0 same cycle.
REQ-036 x3 pending tag 5, issue tag 7 to x3, then commit tag 5 value 0x11 -> regs[3]=0x11, dep stays tag 7, busy_count=1.
REQ-037 Same cycle commit tag 7 to x3 and issue tag 9 to x3 -> regs[3] updated, dep_id[3]=9; read port on x3 that cycle sees commit_value.
REQ-038 Issue tag 4 to x0, commit value 0x55 to x0 -> x0 reads 0, no dep, busy_count unchanged.
REQ-039 Three registers pending, assert flush with simultaneous issue to x8 -> all deps cleared, busy_count=0; assert rst mid-flush -> all state zero asynchronously.

Source files
------------

// File: rtl/reg_status_pkg.sv
// Shared configuration for the register status block: default register-file
// geometry and RoB tag width. Everything else is derived from these.
package reg_status_pkg;

  // Width of a reorder-buffer tag. Tag 0 is reserved to mean "none".
  localparam int ROB_SIZE_WIDTH = 4;

  // Data width of an architectural register.
  localparam int XLEN_WIDTH = 32;

  // Number of architectural registers and the matching index width.
  localparam int NREG_COUNT    = 32;
  localparam int REG_IDX_WIDTH = $clog2(NREG_COUNT);

endpackage

// File: rtl/reg_status_read_port.sv
// reg_read_port: operand resolution for a single decoder read port.
// Takes the stored state of the selected register and resolves the operand,
// forwarding a same-cycle commit or a ready RoB result when the register is
// still waiting on a producer.
//   addr          : source register index (x0 always reads as zero)
//   reg_value     : stored architectural value of addr
//   reg_has_dep   : addr is currently renamed to an in-flight producer
//   reg_dep_id    : RoB tag of that producer
//   commit_rob_id : tag committing this cycle (0 = none)
//   commit_value  : result of the committing instruction
//   rob_ready     : RoB holds the result for ask_rob_id
//   rob_value     : that RoB result
//   value/has_dep/dep_id : resolved operand
//   ask_rob_id    : tag the RoB is asked about (0 when no dependency)
module reg_read_port #(
  parameter int XLEN  = 32,
  parameter int ROB_W = 4,
  parameter int AW    = 5
) (
  input  logic [AW-1:0]    addr,
  input  logic [XLEN-1:0]  reg_value,
  input  logic             reg_has_dep,
  input  logic [ROB_W-1:0] reg_dep_id,
  input  logic [ROB_W-1:0] commit_rob_id,
  input  logic [XLEN-1:0]  commit_value,
  input  logic             rob_ready,
  input  logic [XLEN-1:0]  rob_value,
  output logic [XLEN-1:0]  value,
  output logic             has_dep,
  output logic [ROB_W-1:0] dep_id,
  output logic [ROB_W-1:0] ask_rob_id
);

  assign ask_rob_id = reg_has_dep ? reg_dep_id : '0;

  always_comb begin
    value   = '0;
    has_dep = 1'b0;
    dep_id  = '0;
    if (addr == '0) begin
      value = '0;
    end else if (!reg_has_dep) begin
      value = reg_value;
    end else if (commit_rob_id != '0 && commit_rob_id == reg_dep_id) begin
      // Producer is committing right now: take its result directly.
      value = commit_value;
    end else if (rob_ready) begin
      value = rob_value;
    end else begin
      has_dep = 1'b1;
      dep_id  = reg_dep_id;
    end
  end

endmodule

// File: rtl/reg_status.sv
// reg_status: architectural register file with rename (dependency) tracking.
// Each register holds its committed value plus an optional RoB tag of the
// youngest in-flight producer. Issue renames, commit writes back and clears
// the rename only if it is still the latest one, flush drops all renames.
//   clk, rst (async, active-low), rdy (global enable)
//   issue_rob_id/issue_rd           : rename request (tag 0 = none)
//   commit_rob_id/commit_rd/value   : write-back (tag 0 = none)
//   flush                           : discard all speculative renames
//   rd_addr -> rd_value/rd_has_dep/rd_dep_id : NRP combinational read ports
//   ask_rob_id <- rob_ready/rob_value        : per-port RoB lookup
//   busy_count                      : number of registers with a dependency
module reg_status
  import reg_status_pkg::*;
#(
  parameter int NREG  = NREG_COUNT,
  parameter int XLEN  = XLEN_WIDTH,
  parameter int ROB_W = ROB_SIZE_WIDTH,
  parameter int NRP   = 2,
  localparam int AW   = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic [ROB_W-1:0]    issue_rob_id,
  input  logic [AW-1:0]       issue_rd,
  input  logic [ROB_W-1:0]    commit_rob_id,
  input  logic [AW-1:0]       commit_rd,
  input  logic [XLEN-1:0]     commit_value,
  input  logic                flush,
  input  logic [NRP*AW-1:0]   rd_addr,
  output logic [NRP*XLEN-1:0] rd_value,
  output logic [NRP-1:0]      rd_has_dep,
  output logic [NRP*ROB_W-1:0] rd_dep_id,
  output logic [NRP*ROB_W-1:0] ask_rob_id,
  input  logic [NRP-1:0]      rob_ready,
  input  logic [NRP*XLEN-1:0] rob_value,
  output logic [AW:0]         busy_count
);

  logic [XLEN-1:0]  regs   [NREG];
  logic [ROB_W-1:0] dep_id [NREG];
  logic [NREG-1:0]  has_dep;
  logic [AW:0]      busy;

  logic do_commit;
  logic do_issue;
  logic commit_clear;
  logic busy_inc;
  logic busy_dec;

  assign do_commit    = rdy && commit_rob_id != '0 && commit_rd != '0;
  assign do_issue     = rdy && !flush && issue_rob_id != '0 && issue_rd != '0;
  assign commit_clear = do_commit && has_dep[commit_rd] && dep_id[commit_rd] == commit_rob_id;

  // A rename of an already-busy register does not add to the count, and a
  // clearing commit that loses to a same-register issue does not subtract.
  assign busy_inc = do_issue && !has_dep[issue_rd];
  assign busy_dec = commit_clear && !(do_issue && issue_rd == commit_rd);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i]   <= '0;
        dep_id[i] <= '0;
      end
      has_dep <= '0;
      busy    <= '0;
    end else if (rdy) begin
      if (do_commit) regs[commit_rd] <= commit_value;
      if (flush) begin
        has_dep <= '0;
        for (int i = 0; i < NREG; i++) dep_id[i] <= '0;
        busy <= '0;
      end else begin
        if (commit_clear) begin
          has_dep[commit_rd] <= 1'b0;
          dep_id[commit_rd]  <= '0;
        end
        // Placed after the clear so a same-register issue keeps its rename.
        if (do_issue) begin
          has_dep[issue_rd] <= 1'b1;
          dep_id[issue_rd]  <= issue_rob_id;
        end
        busy <= busy + (AW+1)'(busy_inc) - (AW+1)'(busy_dec);
      end
    end
  end

  assign busy_count = busy;

  generate
    for (genvar gi = 0; gi < NRP; gi++) begin : g_port
      logic [AW-1:0] addr;
      assign addr = rd_addr[gi*AW +: AW];

      reg_read_port #(
        .XLEN  (XLEN),
        .ROB_W (ROB_W),
        .AW    (AW)
      ) u_port (
        .addr          (addr),
        .reg_value     (regs[addr]),
        .reg_has_dep   (has_dep[addr]),
        .reg_dep_id    (dep_id[addr]),
        .commit_rob_id (commit_rob_id),
        .commit_value  (commit_value),
        .rob_ready     (rob_ready[gi]),
        .rob_value     (rob_value[gi*XLEN +: XLEN]),
        .value         (rd_value[gi*XLEN +: XLEN]),
        .has_dep       (rd_has_dep[gi]),
        .dep_id        (rd_dep_id[gi*ROB_W +: ROB_W]),
        .ask_rob_id    (ask_rob_id[gi*ROB_W +: ROB_W])
      );
    end
  endgenerate

endmodule

// File: tb/tb_reg_status.sv
module tb_reg_status;
  localparam int NREG  = 32;
  localparam int XLEN  = 32;
  localparam int ROB_W = 4;
  localparam int NRP   = 2;
  localparam int AW    = 5;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  rdy = 1'b0;
  logic [ROB_W-1:0]      issue_rob_id = '0;
  logic [AW-1:0]         issue_rd = '0;
  logic [ROB_W-1:0]      commit_rob_id = '0;
  logic [AW-1:0]         commit_rd = '0;
  logic [XLEN-1:0]       commit_value = '0;
  logic                  flush = 1'b0;
  logic [NRP*AW-1:0]     rd_addr = '0;
  logic [NRP*XLEN-1:0]   rd_value;
  logic [NRP-1:0]        rd_has_dep;
  logic [NRP*ROB_W-1:0]  rd_dep_id;
  logic [NRP*ROB_W-1:0]  ask_rob_id;
  logic [NRP-1:0]        rob_ready = '0;
  logic [NRP*XLEN-1:0]   rob_value = '0;
  logic [AW:0]           busy_count;

  int total = 0;
  int bad   = 0;

  // Reference model: committed values and the pending tag per register
  // (tag 0 means no pending producer).
  longint m_regs [NREG];
  int     m_dep  [NREG];

  reg_status #(.NREG(NREG), .XLEN(XLEN), .ROB_W(ROB_W), .NRP(NRP)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .issue_rob_id(issue_rob_id), .issue_rd(issue_rd),
    .commit_rob_id(commit_rob_id), .commit_rd(commit_rd), .commit_value(commit_value),
    .flush(flush), .rd_addr(rd_addr),
    .rd_value(rd_value), .rd_has_dep(rd_has_dep), .rd_dep_id(rd_dep_id),
    .ask_rob_id(ask_rob_id), .rob_ready(rob_ready), .rob_value(rob_value),
    .busy_count(busy_count)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_busy();
    int n = 0;
    for (int i = 0; i < NREG; i++) if (m_dep[i] != 0) n++;
    return n;
  endfunction

  // Model state update.
  initial begin
    for (int i = 0; i < NREG; i++) begin m_regs[i] = 0; m_dep[i] = 0; end
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        for (int i = 0; i < NREG; i++) begin m_regs[i] = 0; m_dep[i] = 0; end
      end else if (rdy) begin
        if (commit_rob_id != 0 && commit_rd != 0) begin
          m_regs[commit_rd] = longint'(commit_value);
          if (m_dep[commit_rd] == int'(commit_rob_id)) m_dep[commit_rd] = 0;
        end
        if (flush) begin
          for (int i = 0; i < NREG; i++) m_dep[i] = 0;
        end else if (issue_rob_id != 0 && issue_rd != 0) begin
          m_dep[issue_rd] = int'(issue_rob_id);
        end
      end
    end
  end

  // Per-cycle comparison of all outputs against the model.
  initial forever begin
    @(negedge clk);
    for (int p = 0; p < NRP; p++) begin
      int     a;
      longint ev;
      int     eh, ed;
      a  = int'(rd_addr[p*AW +: AW]);
      ev = 0; eh = 0; ed = 0;
      if (a == 0) ev = 0;
      else if (m_dep[a] == 0) ev = m_regs[a];
      else if (commit_rob_id != 0 && int'(commit_rob_id) == m_dep[a]) ev = longint'(commit_value);
      else if (rob_ready[p]) ev = longint'(rob_value[p*XLEN +: XLEN]);
      else begin eh = 1; ed = m_dep[a]; end
      chk($sformatf("port%0d value", p), longint'(rd_value[p*XLEN +: XLEN]), ev);
      chk($sformatf("port%0d has_dep", p), longint'(rd_has_dep[p]), longint'(eh));
      chk($sformatf("port%0d dep_id", p), longint'(rd_dep_id[p*ROB_W +: ROB_W]), longint'(ed));
      chk($sformatf("port%0d ask_rob_id", p), longint'(ask_rob_id[p*ROB_W +: ROB_W]), longint'(m_dep[a]));
    end
    chk("busy_count", longint'(busy_count), longint'(model_busy()));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int a0, input int a1);
    rd_addr = {AW'(a1), AW'(a0)};
  endtask

  initial begin
    #1;
    chk("reset busy_count", longint'(busy_count), 0);
    chk("reset port0 has_dep", longint'(rd_has_dep[0]), 0);
    #1 rst = 1'b1;
    rdy = 1'b1;
    tick();

    // Rename x3 to tag 5 and read it back while pending.
    issue_rob_id = 4'd5; issue_rd = 5'd3;
    tick();
    issue_rob_id = 0; issue_rd = 0;
    set_addr(3, 0);
    #1;
    chk("pending has_dep", longint'(rd_has_dep[0]), 1);
    chk("pending dep_id", longint'(rd_dep_id[3:0]), 5);
    chk("pending ask_rob_id", longint'(ask_rob_id[3:0]), 5);
    chk("pending busy_count", longint'(busy_count), 1);
    // RoB already holds the result: forwarded in the same cycle.
    rob_ready = 2'b01; rob_value = {32'h0, 32'h0000_DEAD};
    #1;
    chk("rob fwd value", longint'(rd_value[31:0]), 64'hDEAD);
    chk("rob fwd has_dep", longint'(rd_has_dep[0]), 0);
    tick();

    // Re-rename x3 to tag 7, then stale commit of tag 5.
    rob_ready = 0; rob_value = 0;
    issue_rob_id = 4'd7; issue_rd = 5'd3;
    tick();
    issue_rob_id = 0; issue_rd = 0;
    commit_rob_id = 4'd5; commit_rd = 5'd3; commit_value = 32'h11;
    tick();
    commit_rob_id = 0; commit_rd = 0; commit_value = 0;
    #1;
    chk("stale commit dep_id", longint'(rd_dep_id[3:0]), 7);
    chk("stale commit busy", longint'(busy_count), 1);
    tick();

    // Commit tag 7 and issue tag 9 to x3 together.
    commit_rob_id = 4'd7; commit_rd = 5'd3; commit_value = 32'h77;
    issue_rob_id = 4'd9; issue_rd = 5'd3;
    #1;
    chk("commit fwd value", longint'(rd_value[31:0]), 64'h77);
    chk("commit fwd has_dep", longint'(rd_has_dep[0]), 0);
    tick();
    commit_rob_id = 0; commit_rd = 0; commit_value = 0;
    issue_rob_id = 0; issue_rd = 0;
    #1;
    chk("issue wins dep_id", longint'(rd_dep_id[3:0]), 9);
    chk("issue wins busy", longint'(busy_count), 1);

    // Writes to x0 are ignored.
    issue_rob_id = 4'd4; issue_rd = 5'd0;
    commit_rob_id = 4'd4; commit_rd = 5'd0; commit_value = 32'h55;
    tick();
    issue_rob_id = 0; commit_rob_id = 0; commit_value = 0;
    set_addr(3, 0);
    #1;
    chk("x0 value", longint'(rd_value[63:32]), 0);
    chk("x0 has_dep", longint'(rd_has_dep[1]), 0);
    chk("x0 busy unchanged", longint'(busy_count), 1);

    // Final commit of tag 9 to x3.
    commit_rob_id = 4'd9; commit_rd = 5'd3; commit_value = 32'h99;
    tick();
    commit_rob_id = 0; commit_rd = 0; commit_value = 0;
    #1;
    chk("x3 committed value", longint'(rd_value[31:0]), 64'h99);
    chk("idle busy", longint'(busy_count), 0);

    // rdy low freezes state.
    rdy = 0; issue_rob_id = 4'd6; issue_rd = 5'd5;
    tick();
    issue_rob_id = 0; issue_rd = 0; rdy = 1;
    set_addr(5, 3);
    #1;
    chk("frozen has_dep", longint'(rd_has_dep[0]), 0);
    chk("frozen busy", longint'(busy_count), 0);

    // Three pending registers, then flush with an issue and a commit.
    issue_rob_id = 4'd1; issue_rd = 5'd1; tick();
    issue_rob_id = 4'd2; issue_rd = 5'd2; tick();
    issue_rob_id = 4'd3; issue_rd = 5'd4; tick();
    issue_rob_id = 0; issue_rd = 0;
    #1;
    chk("three pending busy", longint'(busy_count), 3);
    flush = 1; issue_rob_id = 4'd8; issue_rd = 5'd8;
    commit_rob_id = 4'd2; commit_rd = 5'd2; commit_value = 32'h22;
    tick();
    flush = 0; issue_rob_id = 0; issue_rd = 0;
    commit_rob_id = 0; commit_rd = 0; commit_value = 0;
    set_addr(8, 2);
    #1;
    chk("flush busy", longint'(busy_count), 0);
    chk("flush x8 has_dep", longint'(rd_has_dep[0]), 0);
    chk("flush commit x2", longint'(rd_value[63:32]), 64'h22);

    // Asynchronous reset in the middle of a flush cycle.
    issue_rob_id = 4'd1; issue_rd = 5'd1; tick();
    issue_rob_id = 0; issue_rd = 0;
    set_addr(1, 2);
    flush = 1;
    #2 rst = 0;
    #1;
    chk("async rst busy", longint'(busy_count), 0);
    chk("async rst x1 has_dep", longint'(rd_has_dep[0]), 0);
    chk("async rst x2 value", longint'(rd_value[63:32]), 0);
    tick();
    #2 rst = 1; flush = 0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
